// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/subtract, carry ripples one chunk per stage with a global-stall handshake.
// Define PIPE_ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   // Subtract as a + ~b + ~c_in so every stage is a plain adder.
   assign b_eff    = sub ? ~b : b;
   assign c_eff    = c_in ^ sub;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      logic             v_i;
      logic             c_i;
      logic [WIDTH-1:0] a_i;
      logic [WIDTH-1:0] b_i;
      logic [WIDTH-1:0] r_i;
      logic [WIDTH-1:0] r_n;
      logic [WIDTH-1:0] r_f;
      logic [CW:0]      t;
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] r_q;

      if (k == 0) begin : g_src
         assign v_i = in_valid;
         assign a_i = a;
         assign b_i = b_eff;
         assign c_i = c_eff;
         assign r_i = '0;
      end else begin : g_src
         assign v_i = stg[k-1].v_q;
         assign a_i = stg[k-1].g_ops.a_q;
         assign b_i = stg[k-1].g_ops.b_q;
         assign c_i = stg[k-1].c_q;
         assign r_i = stg[k-1].r_q;
      end

      assign t = {1'b0, a_i[k*CW +: CW]} + {1'b0, b_i[k*CW +: CW]} + {{CW{1'b0}}, c_i};

      always_comb begin
         r_n = r_i;
         r_n[k*CW +: CW] = t[CW-1:0];
      end

      if (k < STAGES - 1) begin : g_ops
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;

         assign r_f = r_n;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_i;
               b_q <= b_i;
            end
         end
      end else begin : g_last
         logic c_msb;
         logic ovf_n;
         logic ovf_q;

         // Carry into the MSB recovered from the MSB sum bit and its operand bits.
         assign c_msb = t[CW-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1];
         assign ovf_n = c_msb ^ t[CW];
`ifdef PIPE_ADDSUB_SAT_EN
         assign r_f = ovf_n ? {a_i[WIDTH-1], {(WIDTH-1){~a_i[WIDTH-1]}}} : r_n;
`else
         assign r_f = r_n;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_n;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            r_q <= '0;
         end else if (adv) begin
            v_q <= v_i;
            c_q <= t[CW];
            r_q <= r_f;
         end
      end
   end

   assign out_valid = stg[STAGES-1].v_q;
   assign sum       = stg[STAGES-1].r_q;
   assign c_out     = stg[STAGES-1].c_q;
   assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit with a valid/ready handshake. It is the next-generation replacement for the team's fixed 16-bit combinational full adder. Operands are split into `STAGES` equal chunks, and the carry ripples one chunk per clock, so `WIDTH` scales without lengthening the critical path. The unit sits between an operand producer and a result consumer, and either side may stall.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth. Chunk width is `CW = WIDTH/STAGES`. `STAGES = 1` is legal.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operand beat valid.
- `in_ready` output, 1: unit accepts the beat this cycle.
- `a` input, `WIDTH`: operand A.
- `b` input, `WIDTH`: operand B.
- `c_in` input, 1: carry-in (add) or borrow-in (subtract).
- `sub` input, 1: 0 selects `a+b+c_in`; 1 selects `a-b-c_in`.
- `out_valid` output, 1: result beat valid.
- `out_ready` input, 1: consumer accepts the result.
- `sum` output, `WIDTH`: result.
- `c_out` output, 1: carry out of the MSB (raw adder carry; in subtract mode 1 means no borrow).
- `ovf` output, 1: two's-complement signed overflow.

## Operation
- Subtract is implemented as `a + ~b + (~c_in)`, which equals `a - b - c_in` mod 2^WIDTH.
- Stage k (0..STAGES-1) adds chunk k of A with chunk k of effective B, plus the carry registered by stage k-1.
  - Stage 0 uses the effective carry-in.
  - Chunks above k travel delayed alongside; result chunks below k are held.
- Each stage register holds:
  - a valid bit,
  - the partial result,
  - the remaining operand chunks,
  - the carry,
  - the carry into the MSB (captured in the last stage).
- Pipeline advance: `adv = ~out_valid | out_ready`. All stages shift together when `adv` is 1 and hold otherwise; this is a global stall.
- `in_ready = adv`. A beat is accepted when `in_valid & in_ready`.
- When `adv=1` and no beat is accepted, stage 0 loads valid=0, creating a bubble.
- Flags:
  - `c_out` = carry out of bit WIDTH-1.
  - `ovf` = carry into MSB XOR carry out of MSB.
- Results emerge in acceptance order. There is no reordering or dropping.

## Timing
- Reset (`rst_n` low, asynchronous): all valid bits, `out_valid`, `sum`, `c_out` and `ovf` are 0.
  - Reset mid-operation discards all in-flight beats.
  - The first beat is accepted on the first rising edge after `rst_n` deasserts.
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+STAGES-1. With STAGES=4 it is visible after the 4th edge including the accept.
- Throughput: one beat per clock while `out_ready=1`.
- `out_ready=0` with `out_valid=1` holds:
  - all stages,
  - `sum`, `c_out` and `ovf` stable,
  - `in_ready=0` in the same cycle, combinationally.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- Inputs are sampled only on an accepting edge. They may change freely otherwise.
- `STAGES=1`: the single registered stage gives latency 1.

## Configuration
- `PIPE_ADDSUB_SAT_EN` defined:
  - When `ovf=1`, `sum` saturates to the signed maximum (`0111…1`) if the true result is positive, or the signed minimum (`1000…0`) if negative.
  - The sign is taken from operand A's MSB.
  - `ovf` is still reported and `c_out` is unaffected.
  - Saturation is applied in the last stage, so latency is unchanged.
- Macro undefined: `sum` wraps modulo 2^WIDTH and `ovf` is reported only.

## Test plan
All scenarios use WIDTH=16 and STAGES=4.
- Reset: assert `rst_n=0` mid-stream with 3 beats in flight → `out_valid`, `sum`, `c_out` and `ovf` are 0 immediately. No stale beat appears after release.
- Add with carry chain: a=16'hFFFF, b=16'h0000, c_in=1, sub=0 → after 4 edges, sum=16'h0000, c_out=1, ovf=0.
- Subtract and overflow: a=16'h8000, b=16'h0001, c_in=0, sub=1 → sum=16'h7FFF, ovf=1, c_out=1.
  - With `PIPE_ADDSUB_SAT_EN`: sum=16'h8000.
  - Also a=16'h7FFF, b=1, add → sum=16'h8000 when wrapping, 16'h7FFF when saturating, ovf=1.
- Streaming: 16×16×2 sweep of a=i, b=j, c_in=k, issued back-to-back with `out_ready=1` → one result per clock, each equal to i+j+k in order, first result 4 cycles after the first accept.
- Backpressure: toggle `out_ready` pseudo-randomly while `in_valid` is random → `in_ready==adv` every cycle, the held output is stable, and the scoreboard matches all 512 beats in order with no loss or duplication.
- Mixed mode: alternate `sub` per beat with a=16'h1234, b=16'h0235, c_in=1 → results alternate 16'h146A and 16'h0FFE.
